// File: rtl/rename_alloc_pkg.sv
// Shared types and sizing constants for the rename/allocate stage.
// Optional feature macro used by this slice: RENAME_STATS_EN.
package rename_alloc_pkg;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int ROB_DEPTH = 32;
  localparam int PREG_W    = $clog2(NUM_PREGS);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [4:0]        areg_t;
  typedef logic [4:0]        rob_idx_t;
  typedef logic [6:0]        fl_count_t;
  typedef logic [5:0]        rob_count_t;

  function automatic logic [1:0] bitCount2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/rename_alloc_if.sv
// Dispatch, rename-result and retirement signals between dispatch, renamer and ROB.
interface rename_alloc_if;
  import rename_alloc_pkg::*;

  logic     req_1, req_2;
  areg_t    areg_d_1, areg_d_2;
  areg_t    areg_s1_1, areg_s1_2;
  areg_t    areg_s2_1, areg_s2_2;
  logic     grant;
  preg_t    curr_dest_reg_1, curr_dest_reg_2;
  preg_t    old_dest_reg_1, old_dest_reg_2;
  rob_idx_t rob_index_1, rob_index_2;
  logic     out_valid_1, out_valid_2;
  preg_t    psrc1_1, psrc1_2, psrc2_1, psrc2_2;
  logic [1:0] num_retired;
  logic     free_valid_1, free_valid_2;
  preg_t    free_preg_1, free_preg_2;

  modport master (
    output req_1, req_2, areg_d_1, areg_d_2, areg_s1_1, areg_s1_2,
           areg_s2_1, areg_s2_2, num_retired, free_valid_1, free_valid_2,
           free_preg_1, free_preg_2,
    input  grant, curr_dest_reg_1, curr_dest_reg_2, old_dest_reg_1,
           old_dest_reg_2, rob_index_1, rob_index_2, out_valid_1,
           out_valid_2, psrc1_1, psrc1_2, psrc2_1, psrc2_2
  );

  modport slave (
    input  req_1, req_2, areg_d_1, areg_d_2, areg_s1_1, areg_s1_2,
           areg_s2_1, areg_s2_2, num_retired, free_valid_1, free_valid_2,
           free_preg_1, free_preg_2,
    output grant, curr_dest_reg_1, curr_dest_reg_2, old_dest_reg_1,
           old_dest_reg_2, rob_index_1, rob_index_2, out_valid_1,
           out_valid_2, psrc1_1, psrc1_2, psrc2_1, psrc2_2
  );

endinterface

// File: rtl/free_list_fifo.sv
// Circular free list of physical registers: up to two pops and two pushes per cycle.
// Reset contents are p32..p63, i.e. every preg not covered by the identity RAT.
module free_list_fifo
  import rename_alloc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic [1:0] pop_cnt_i,
  output preg_t     head_0_o,
  output preg_t     head_1_o,
  input  logic      push_1_i,
  input  preg_t     push_preg_1_i,
  input  logic      push_2_i,
  input  preg_t     push_preg_2_i,
  output fl_count_t count_o
);

  preg_t      mem_q [NUM_PREGS];
  preg_t      head_q, tail_q;
  fl_count_t  count_q;
  logic [1:0] pushes;
  logic [7:0] countNext;

  assign pushes    = bitCount2(push_1_i, push_2_i);
  assign countNext = {1'b0, count_q} + {6'b0, pushes} - {6'b0, pop_cnt_i};

  assign head_0_o = mem_q[head_q];
  assign head_1_o = mem_q[head_q + preg_t'(1)];
  assign count_o  = count_q;

  // A lone slot-2 push compacts into the tail so the queue never has holes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++) mem_q[i] <= preg_t'(i + NUM_PREGS / 2);
      head_q  <= '0;
      tail_q  <= preg_t'(NUM_PREGS / 2);
      count_q <= fl_count_t'(NUM_PREGS / 2);
    end else begin
      if (push_1_i) mem_q[tail_q] <= push_preg_1_i;
      if (push_2_i) mem_q[push_1_i ? tail_q + preg_t'(1) : tail_q] <= push_preg_2_i;
      head_q  <= head_q + {4'b0, pop_cnt_i};
      tail_q  <= tail_q + {4'b0, pushes};
      count_q <= countNext[6:0];
    end
  end

  assert property (@(posedge clk) disable iff (rst) (countNext <= 8'(NUM_PREGS)));

endmodule

// File: rtl/rename_alloc.sv
// Two-wide register renamer and ROB slot allocator feeding the reorder buffer.
// Optional stall counter port stall_cnt_o exists only with RENAME_STATS_EN defined.
module rename_alloc
  import rename_alloc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  rename_alloc_if.slave bus
`ifdef RENAME_STATS_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  preg_t      rat_q [NUM_AREGS];
  rob_idx_t   robTail_q;
  rob_count_t robCount_q, robCount_d, robFree;
  fl_count_t  flCount;
  preg_t      head0, head1;
  logic       hasDest1, hasDest2, grant;
  logic [1:0] needPregs, needRob;

  preg_t    curr1_q, curr2_q, old1_q, old2_q;
  preg_t    src11_q, src21_q, src12_q, src22_q;
  rob_idx_t rob1_q, rob2_q;
  logic     valid1_q, valid2_q;

  preg_t curr1, curr2, old1, old2, src11, src21, src12, src22;

  assign hasDest1  = bus.req_1 && (bus.areg_d_1 != '0);
  assign hasDest2  = bus.req_2 && (bus.areg_d_2 != '0);
  assign needPregs = bitCount2(hasDest1, hasDest2);
  assign needRob   = bitCount2(bus.req_1, bus.req_2);
  assign robFree   = rob_count_t'(ROB_DEPTH) - robCount_q;

  // All-or-nothing: both slots must fit against start-of-cycle counts.
  assign grant = !rst && bus.req_1 && (flCount >= {5'b0, needPregs})
               && (robFree >= {4'b0, needRob});

  assign robCount_d = robCount_q - {4'b0, bus.num_retired}
                    + (grant ? {4'b0, needRob} : 6'd0);

  free_list_fifo u_free_list (
    .clk           (clk),
    .rst           (rst),
    .pop_cnt_i     (grant ? needPregs : 2'd0),
    .head_0_o      (head0),
    .head_1_o      (head1),
    .push_1_i      (bus.free_valid_1 && (bus.free_preg_1 != '0)),
    .push_preg_1_i (bus.free_preg_1),
    .push_2_i      (bus.free_valid_2 && (bus.free_preg_2 != '0)),
    .push_preg_2_i (bus.free_preg_2),
    .count_o       (flCount)
  );

  // Slot 2 sees slot 1's new mapping for any areg that slot 1 writes.
  always_comb begin
    curr1 = hasDest1 ? head0 : '0;
    curr2 = '0;
    if (hasDest2) curr2 = hasDest1 ? head1 : head0;
    old1  = hasDest1 ? rat_q[bus.areg_d_1] : '0;
    old2  = '0;
    if (hasDest2) old2 = (hasDest1 && bus.areg_d_2 == bus.areg_d_1) ? curr1 : rat_q[bus.areg_d_2];
    src11 = (bus.areg_s1_1 == '0) ? '0 : rat_q[bus.areg_s1_1];
    src21 = (bus.areg_s2_1 == '0) ? '0 : rat_q[bus.areg_s2_1];
    src12 = (bus.areg_s1_2 == '0) ? '0 : rat_q[bus.areg_s1_2];
    src22 = (bus.areg_s2_2 == '0) ? '0 : rat_q[bus.areg_s2_2];
    if (hasDest1 && bus.areg_s1_2 == bus.areg_d_1) src12 = curr1;
    if (hasDest1 && bus.areg_s2_2 == bus.areg_d_1) src22 = curr1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREGS; i++) rat_q[i] <= preg_t'(i);
      robTail_q  <= '0;
      robCount_q <= '0;
      valid1_q   <= 1'b0;
      valid2_q   <= 1'b0;
      curr1_q    <= '0;
      curr2_q    <= '0;
      old1_q     <= '0;
      old2_q     <= '0;
      src11_q    <= '0;
      src21_q    <= '0;
      src12_q    <= '0;
      src22_q    <= '0;
      rob1_q     <= '0;
      rob2_q     <= '0;
    end else begin
      valid1_q   <= grant && bus.req_1;
      valid2_q   <= grant && bus.req_2;
      robCount_q <= robCount_d;
      if (grant) begin
        curr1_q   <= curr1;
        curr2_q   <= curr2;
        old1_q    <= old1;
        old2_q    <= old2;
        src11_q   <= src11;
        src21_q   <= src21;
        src12_q   <= src12;
        src22_q   <= src22;
        rob1_q    <= robTail_q;
        rob2_q    <= robTail_q + rob_idx_t'(1);
        robTail_q <= robTail_q + {3'b0, needRob};
        if (hasDest1) rat_q[bus.areg_d_1] <= curr1;
        if (hasDest2) rat_q[bus.areg_d_2] <= curr2;
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) ({4'b0, bus.num_retired} <= robCount_q));

  assign bus.grant           = grant;
  assign bus.out_valid_1     = valid1_q;
  assign bus.out_valid_2     = valid2_q;
  assign bus.curr_dest_reg_1 = curr1_q;
  assign bus.curr_dest_reg_2 = curr2_q;
  assign bus.old_dest_reg_1  = old1_q;
  assign bus.old_dest_reg_2  = old2_q;
  assign bus.rob_index_1     = rob1_q;
  assign bus.rob_index_2     = rob2_q;
  assign bus.psrc1_1         = src11_q;
  assign bus.psrc2_1         = src21_q;
  assign bus.psrc1_2         = src12_q;
  assign bus.psrc2_2         = src22_q;

`ifdef RENAME_STATS_EN
  logic [31:0] stallCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stallCnt_q <= '0;
    else if (bus.req_1 && !grant && stallCnt_q != '1) stallCnt_q <= stallCnt_q + 32'd1;
  end

  assign stall_cnt_o = stallCnt_q;
`endif

endmodule
